// File: rtl/pcs_transmit.sv
// 1000BASE-X PCS transmit: GMII octets to 8b/10b code-groups with /I/ /S/ /T/ /R/ /V/ ordered sets.
// Define PCS_TX_ERR_PROP_EN to turn TX_ER during a frame into /V/; otherwise TX_ER is ignored.
module pcs_transmit (
    input  logic       Clk,
    input  logic       mr_main_reset,
    input  logic [7:0] TXD,
    input  logic       TX_EN,
    input  logic       TX_ER,
    output logic [9:0] tx_code_group,
    output logic       tx_even,
    output logic       transmitting,
    output logic       rd_positive
);

    typedef enum logic [1:0] {IDLE, DATA, EPD_R, EPD_R2} state_t;

    typedef struct packed {
        logic       k;
        logic [7:0] oct;
    } sym_t;

    localparam sym_t SYM_K28_5 = '{k: 1'b1, oct: 8'hBC};
    localparam sym_t SYM_K27_7 = '{k: 1'b1, oct: 8'hFB};
    localparam sym_t SYM_K29_7 = '{k: 1'b1, oct: 8'hFD};
    localparam sym_t SYM_K23_7 = '{k: 1'b1, oct: 8'hF7};
    localparam sym_t SYM_K30_7 = '{k: 1'b1, oct: 8'hFE};
    localparam sym_t SYM_D16_2 = '{k: 1'b0, oct: 8'h50};
    localparam sym_t SYM_D5_6  = '{k: 1'b0, oct: 8'hC5};

    state_t     state;
    state_t     state_nxt;
    sym_t       sym;
    logic       tx_nxt;
    logic       slot_even;
    logic       err_oct;

`ifdef PCS_TX_ERR_PROP_EN
    assign err_oct = TX_ER;
`else
    logic tx_er_unused;
    assign tx_er_unused = TX_ER;
    assign err_oct      = 1'b0;
`endif

    // slot being produced at the coming edge
    assign slot_even = ~tx_even;

    always_comb begin
        sym       = SYM_K28_5;
        state_nxt = state;
        tx_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (slot_even) begin
                    if (TX_EN) begin
                        sym       = SYM_K27_7;
                        tx_nxt    = 1'b1;
                        state_nxt = DATA;
                    end else begin
                        sym = SYM_K28_5;
                    end
                end else begin
                    // RD+ here means the K28.5 went out at RD-, so /I2/ restores RD-
                    sym = rd_positive ? SYM_D16_2 : SYM_D5_6;
                end
            end
            DATA: begin
                tx_nxt = 1'b1;
                if (!TX_EN) begin
                    sym       = SYM_K29_7;
                    state_nxt = EPD_R;
                end else if (err_oct) begin
                    sym = SYM_K30_7;
                end else begin
                    sym = '{k: 1'b0, oct: TXD};
                end
            end
            EPD_R: begin
                sym       = SYM_K23_7;
                state_nxt = slot_even ? EPD_R2 : IDLE;
            end
            EPD_R2: begin
                sym       = SYM_K23_7;
                state_nxt = IDLE;
            end
            default: begin
                sym       = SYM_K28_5;
                state_nxt = IDLE;
            end
        endcase
    end

    // 5b/6b RD- column with a nonzero-disparity flag: {nz, abcdei}
    function automatic logic [6:0] tbl6(input logic [4:0] x);
        logic [6:0] r;
        case (x)
            5'd0:  r = {1'b1, 6'b100111};
            5'd1:  r = {1'b1, 6'b011101};
            5'd2:  r = {1'b1, 6'b101101};
            5'd3:  r = {1'b0, 6'b110001};
            5'd4:  r = {1'b1, 6'b110101};
            5'd5:  r = {1'b0, 6'b101001};
            5'd6:  r = {1'b0, 6'b011001};
            5'd7:  r = {1'b0, 6'b111000};
            5'd8:  r = {1'b1, 6'b111001};
            5'd9:  r = {1'b0, 6'b100101};
            5'd10: r = {1'b0, 6'b010101};
            5'd11: r = {1'b0, 6'b110100};
            5'd12: r = {1'b0, 6'b001101};
            5'd13: r = {1'b0, 6'b101100};
            5'd14: r = {1'b0, 6'b011100};
            5'd15: r = {1'b1, 6'b010111};
            5'd16: r = {1'b1, 6'b011011};
            5'd17: r = {1'b0, 6'b100011};
            5'd18: r = {1'b0, 6'b010011};
            5'd19: r = {1'b0, 6'b110010};
            5'd20: r = {1'b0, 6'b001011};
            5'd21: r = {1'b0, 6'b101010};
            5'd22: r = {1'b0, 6'b011010};
            5'd23: r = {1'b1, 6'b111010};
            5'd24: r = {1'b1, 6'b110011};
            5'd25: r = {1'b0, 6'b100110};
            5'd26: r = {1'b0, 6'b010110};
            5'd27: r = {1'b1, 6'b110110};
            5'd28: r = {1'b0, 6'b001110};
            5'd29: r = {1'b1, 6'b101110};
            5'd30: r = {1'b1, 6'b011110};
            default: r = {1'b1, 6'b101011};
        endcase
        return r;
    endfunction

    // 3b/4b RD- column with a nonzero-disparity flag: {nz, fghj}
    function automatic logic [4:0] tbl4(input logic [2:0] y, input logic k, input logic alt7);
        logic [4:0] r;
        case (y)
            3'd0: r = {1'b1, 4'b1011};
            3'd1: r = k ? {1'b0, 4'b0110} : {1'b0, 4'b1001};
            3'd2: r = k ? {1'b0, 4'b1010} : {1'b0, 4'b0101};
            3'd3: r = {1'b0, 4'b1100};
            3'd4: r = {1'b1, 4'b1101};
            3'd5: r = k ? {1'b0, 4'b0101} : {1'b0, 4'b1010};
            3'd6: r = k ? {1'b0, 4'b1001} : {1'b0, 4'b0110};
            default: r = (k || alt7) ? {1'b1, 4'b0111} : {1'b1, 4'b1110};
        endcase
        return r;
    endfunction

    logic [4:0] enc_x;
    logic [2:0] enc_y;
    logic [5:0] six;
    logic [3:0] four;
    logic       nz6;
    logic       nz4;
    logic       rd_mid;
    logic       rd_out;
    logic       alt7;

    assign enc_x = sym.oct[4:0];
    assign enc_y = sym.oct[7:5];

    always_comb begin
        {nz6, six} = tbl6(enc_x);
        if (sym.k && enc_x == 5'd28)
            {nz6, six} = {1'b1, 6'b001111};
        // D.7 is neutral but still has distinct RD- / RD+ forms
        if (rd_positive && (nz6 || enc_x == 5'd7))
            six = ~six;
        rd_mid = rd_positive ^ nz6;

        // A7 avoids a run of five identical bits across the sub-block boundary
        alt7 = !sym.k && (rd_mid ? (enc_x == 5'd11 || enc_x == 5'd13 || enc_x == 5'd14)
                                 : (enc_x == 5'd17 || enc_x == 5'd18 || enc_x == 5'd20));
        {nz4, four} = tbl4(enc_y, sym.k, alt7);
        if (rd_mid && (nz4 || sym.k || enc_y == 3'd3))
            four = ~four;
        rd_out = rd_mid ^ nz4;
    end

    always_ff @(posedge Clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state         <= IDLE;
            tx_code_group <= 10'h245;
            tx_even       <= 1'b0;
            transmitting  <= 1'b0;
            rd_positive   <= 1'b0;
        end else begin
            state         <= state_nxt;
            tx_code_group <= {six, four};
            tx_even       <= ~tx_even;
            transmitting  <= tx_nxt;
            rd_positive   <= rd_out;
        end
    end

endmodule

// File: tb/tb_pcs_transmit.sv
// Scoreboarded bench for pcs_transmit: directed known-answer frames, then random frames vs a popcount-based 8b/10b model.
module tb_pcs_transmit;

    logic       Clk = 1'b0;
    logic       mr_main_reset;
    logic [7:0] TXD;
    logic       TX_EN;
    logic       TX_ER;
    logic [9:0] tx_code_group;
    logic       tx_even;
    logic       transmitting;
    logic       rd_positive;

    pcs_transmit dut (
        .Clk          (Clk),
        .mr_main_reset(mr_main_reset),
        .TXD          (TXD),
        .TX_EN        (TX_EN),
        .TX_ER        (TX_ER),
        .tx_code_group(tx_code_group),
        .tx_even      (tx_even),
        .transmitting (transmitting),
        .rd_positive  (rd_positive)
    );

    always #5 Clk = ~Clk;

`ifdef PCS_TX_ERR_PROP_EN
    localparam bit ERR_PROP = 1'b1;
`else
    localparam bit ERR_PROP = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] code;
        logic       even;
        logic       tx;
        logic       rd;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    // RD- columns; RD+ forms are derived by popcount in m_sym
    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [3:0] T4D [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4K [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};

    bit m_rd;
    bit m_krd;
    bit m_even;

    task automatic m_sym(input bit k, input logic [7:0] b, input bit tx);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] s6;
        logic [3:0] s4;
        exp_t       e;
        x  = b[4:0];
        y  = b[7:5];
        s6 = (k && x == 5'd28) ? 6'b001111 : T6[x];
        if (m_rd && ($countones(s6) != 3 || (!k && x == 5'd7))) s6 = ~s6;
        if ($countones(s6) > 3) m_rd = 1'b1;
        else if ($countones(s6) < 3) m_rd = 1'b0;
        if (k) begin
            s4 = T4K[y];
            if (m_rd) s4 = ~s4;
        end else begin
            s4 = T4D[y];
            if (y == 3'd7 && ((!m_rd && x inside {5'd17, 5'd18, 5'd20}) ||
                              (m_rd && x inside {5'd11, 5'd13, 5'd14})))
                s4 = 4'b0111;
            if (m_rd && ($countones(s4) != 2 || y == 3'd3)) s4 = ~s4;
        end
        if ($countones(s4) > 2) m_rd = 1'b1;
        else if ($countones(s4) < 2) m_rd = 1'b0;
        m_even = ~m_even;
        e.code = {s6, s4};
        e.even = m_even;
        e.tx   = tx;
        e.rd   = m_rd;
        sb_q.push_back(e);
    endtask

    task automatic m_idle();
        if (!m_even) begin
            m_krd = m_rd;
            m_sym(1'b1, 8'hBC, 1'b0);
        end else begin
            m_sym(1'b0, m_krd ? 8'hC5 : 8'h50, 1'b0);
        end
    endtask

    task automatic cyc(input bit en, input bit er, input logic [7:0] d);
        @(negedge Clk);
        TX_EN = en;
        TX_ER = er;
        TXD   = d;
    endtask

    task automatic dstep(input bit en, input bit er, input logic [7:0] d,
                         input logic [9:0] code, input bit ev, input bit tr, input bit rd);
        exp_t e;
        cyc(en, er, d);
        e.code = code;
        e.even = ev;
        e.tx   = tr;
        e.rd   = rd;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_code"}, tx_code_group, 10'h245);
        chk({tag, "_even"}, {9'd0, tx_even}, 10'd0);
        chk({tag, "_tx"},   {9'd0, transmitting}, 10'd0);
        chk({tag, "_rd"},   {9'd0, rd_positive}, 10'd0);
    endtask

    task automatic assert_rst();
        @(posedge Clk);
        #3;
        chk_en        = 1'b0;
        mr_main_reset = 1'b0;
        TX_EN = 1'b0;
        TX_ER = 1'b0;
        TXD   = 8'h00;
        sb_q.delete();
    endtask

    task automatic release_rst();
        @(posedge Clk);
        #3;
        mr_main_reset = 1'b1;
        m_rd   = 1'b0;
        m_krd  = 1'b0;
        m_even = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic run_frame(input int gap, input int n);
        bit         started;
        bit         er;
        bit         r_even;
        logic [7:0] d;
        repeat (gap) begin
            cyc(1'b0, 1'($urandom), 8'($urandom));
            m_idle();
        end
        started = 1'b0;
        for (int i = 0; i < n; i++) begin
            d  = 8'($urandom);
            er = ($urandom_range(0, 9) == 0);
            cyc(1'b1, er, d);
            if (!started) begin
                if (!m_even) begin
                    started = 1'b1;
                    m_sym(1'b1, 8'hFB, 1'b1);
                end else begin
                    m_idle();
                end
            end else if (er && ERR_PROP) begin
                m_sym(1'b1, 8'hFE, 1'b1);
            end else begin
                m_sym(1'b0, d, 1'b1);
            end
        end
        cyc(1'b0, 1'($urandom), 8'($urandom));
        m_sym(1'b1, 8'hFD, 1'b1);
        r_even = !m_even;
        // TX_EN during /R/ is ignored by the DUT
        cyc(1'($urandom), 1'($urandom), 8'($urandom));
        m_sym(1'b1, 8'hF7, 1'b0);
        if (r_even) begin
            cyc(1'($urandom), 1'($urandom), 8'($urandom));
            m_sym(1'b1, 8'hF7, 1'b0);
        end
    endtask

    exp_t mon_e;
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (chk_en && sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                total++;
                if ({tx_code_group, tx_even, transmitting, rd_positive} !== mon_e) begin
                    bad++;
                    $display("FAIL sb t=%0t: got code=%h even=%b tx=%b rd=%b want code=%h even=%b tx=%b rd=%b",
                             $time, tx_code_group, tx_even, transmitting, rd_positive,
                             mon_e.code, mon_e.even, mon_e.tx, mon_e.rd);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        TX_EN = 1'b0;
        TX_ER = 1'b0;
        TXD   = 8'h00;
        mr_main_reset = 1'b1;
        #1;
        mr_main_reset = 1'b0;
        #1;
        chk_reset_vals("por");
        release_rst();

        // idle pairs
        dstep(0, 0, 8'h00, 10'h0FA, 1, 0, 1);
        dstep(0, 0, 8'h00, 10'h245, 0, 0, 0);
        dstep(0, 0, 8'h00, 10'h0FA, 1, 0, 1);
        dstep(0, 0, 8'h00, 10'h245, 0, 0, 0);
        // even-aligned, 4 octets
        dstep(1, 0, 8'h00, 10'h368, 1, 1, 0);
        dstep(1, 0, 8'h00, 10'h274, 0, 1, 0);
        dstep(1, 0, 8'h00, 10'h274, 1, 1, 0);
        dstep(1, 0, 8'h00, 10'h274, 0, 1, 0);
        dstep(0, 0, 8'h00, 10'h2E8, 1, 1, 0);
        dstep(0, 0, 8'h00, 10'h3A8, 0, 0, 0);
        dstep(0, 0, 8'h00, 10'h0FA, 1, 0, 1);
        dstep(0, 0, 8'h00, 10'h245, 0, 0, 0);
        // 3 octets: /T/ on odd slot, two /R/
        dstep(1, 0, 8'h00, 10'h368, 1, 1, 0);
        dstep(1, 0, 8'h00, 10'h274, 0, 1, 0);
        dstep(1, 0, 8'h00, 10'h274, 1, 1, 0);
        dstep(0, 0, 8'h00, 10'h2E8, 0, 1, 0);
        dstep(0, 0, 8'h00, 10'h3A8, 1, 0, 0);
        dstep(0, 0, 8'h00, 10'h3A8, 0, 0, 0);
        dstep(0, 0, 8'h00, 10'h0FA, 1, 0, 1);
        dstep(0, 0, 8'h00, 10'h245, 0, 0, 0);
        // odd-slot start with one errored octet
        dstep(0, 0, 8'h00, 10'h0FA, 1, 0, 1);
        dstep(1, 0, 8'h00, 10'h245, 0, 0, 0);
        dstep(1, 0, 8'h00, 10'h368, 1, 1, 0);
        dstep(1, 0, 8'h00, 10'h274, 0, 1, 0);
        dstep(1, 1, 8'h00, ERR_PROP ? 10'h1E8 : 10'h274, 1, 1, 0);
        dstep(1, 0, 8'h00, 10'h274, 0, 1, 0);
        dstep(0, 0, 8'h00, 10'h2E8, 1, 1, 0);
        dstep(0, 0, 8'h00, 10'h3A8, 0, 0, 0);
        dstep(0, 0, 8'h00, 10'h0FA, 1, 0, 1);
        // reset in the middle of a frame
        dstep(0, 0, 8'h00, 10'h245, 0, 0, 0);
        dstep(1, 0, 8'h00, 10'h368, 1, 1, 0);
        dstep(1, 0, 8'h00, 10'h274, 0, 1, 0);
        @(posedge Clk);
        #3;
        chk_en        = 1'b0;
        mr_main_reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        sb_q.delete();
        repeat (2) @(negedge Clk);
        release_rst();
        dstep(0, 0, 8'h00, 10'h0FA, 1, 0, 1);
        dstep(0, 0, 8'h00, 10'h245, 0, 0, 0);

        // randomized frames against the model
        assert_rst();
        release_rst();
        repeat (300) run_frame($urandom_range(0, 4), $urandom_range(3, 16));
        repeat (4) begin
            cyc(1'b0, 1'b0, 8'h00);
            m_idle();
        end
        @(posedge Clk);
        #3;
        chk("sb_drain", 10'(sb_q.size()), 10'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
